// File: rtl/axi_burst_pkg.sv
// Shared types and AXI constants for the burst engine.
package axi_burst_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_ADDR,
    WR_DATA,
    WR_RESP
  } state_t;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B    = 3'b010;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  localparam int unsigned BEAT_CNT_W = 9;

endpackage

// File: rtl/axi_beat_counter.sv
// Beat counter shared by the read and write data phases; flags the final beat.
module axi_beat_counter
  import axi_burst_pkg::*;
#(
  parameter int unsigned BURST_LEN = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic last
);

  logic [BEAT_CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + BEAT_CNT_W'(1);
    end
  end

  assign last = (count == BEAT_CNT_W'(BURST_LEN - 1));

endmodule

// File: rtl/axi_burst_engine.sv
// Turns sequencer read/write requests into single AXI4 INCR bursts.
// Optional macro WSTRB_PORT_EN adds a per-beat byte-enable input for writes.
module axi_burst_engine
  import axi_burst_pkg::*;
#(
  parameter int unsigned BURST_LEN = 256,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_req,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] addr,
  output logic              axi_done,
  output logic              err,
  output logic [DATA_W-1:0] rd_data,
  input  logic              rd_fifo_full,
  input  logic [DATA_W-1:0] wr_fifo_data,
  input  logic              wr_fifo_empty,
`ifdef WSTRB_PORT_EN
  input  logic [3:0]        wr_fifo_strb,
`endif
  output logic              wr_fifo_rd,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [7:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,
  input  logic              m_rvalid,
  output logic              m_rready,
  output logic [ADDR_W-1:0] m_awaddr,
  output logic [7:0]        m_awlen,
  output logic [2:0]        m_awsize,
  output logic [1:0]        m_awburst,
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [DATA_W-1:0] m_wdata,
  output logic [3:0]        m_wstrb,
  output logic              m_wlast,
  output logic              m_wvalid,
  input  logic              m_wready,
  input  logic [1:0]        m_bresp,
  input  logic              m_bvalid,
  output logic              m_bready
);

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic              last;
  logic              rd_beat;
  logic              wr_beat;
  logic              cnt_clear;

  // Handshake-level controls are decoded straight from the registered state.
  assign m_arvalid  = (state == RD_ADDR);
  assign m_rready   = (state == RD_DATA) && !rd_fifo_full;
  assign m_awvalid  = (state == WR_ADDR);
  assign m_wvalid   = (state == WR_DATA) && !wr_fifo_empty;
  assign m_wlast    = (state == WR_DATA) && last;
  assign m_bready   = (state == WR_RESP);
  assign rd_beat    = m_rvalid && m_rready;
  assign wr_beat    = m_wvalid && m_wready;
  assign wr_fifo_rd = wr_beat;
  assign cnt_clear  = (m_arvalid && m_arready) || (m_awvalid && m_awready);

  assign m_araddr  = addr_q;
  assign m_awaddr  = addr_q;
  assign m_arlen   = 8'(BURST_LEN - 1);
  assign m_awlen   = 8'(BURST_LEN - 1);
  assign m_arsize  = SIZE_4B;
  assign m_awsize  = SIZE_4B;
  assign m_arburst = BURST_INCR;
  assign m_awburst = BURST_INCR;
  assign m_wdata   = wr_fifo_data;
`ifdef WSTRB_PORT_EN
  assign m_wstrb   = wr_fifo_strb;
`else
  assign m_wstrb   = 4'hF;
`endif

  axi_beat_counter #(
    .BURST_LEN (BURST_LEN)
  ) u_beat_counter (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clear),
    .inc   (rd_beat || wr_beat),
    .last  (last)
  );

  // Burst sequencing; a slave error is recorded but never shortens the burst.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      addr_q   <= '0;
      rd_data  <= '0;
      axi_done <= 1'b0;
      err      <= 1'b0;
    end else begin
      axi_done <= 1'b0;
      case (state)
        IDLE: begin
          if (rd_req) begin
            addr_q <= addr;
            state  <= RD_ADDR;
          end else if (wr_req) begin
            addr_q <= addr;
            state  <= WR_ADDR;
          end
        end
        RD_ADDR: begin
          if (m_arready) state <= RD_DATA;
        end
        RD_DATA: begin
          if (rd_beat) begin
            rd_data  <= m_rdata;
            axi_done <= 1'b1;
            if (m_rresp != RESP_OKAY) err <= 1'b1;
            if (m_rlast || last) state <= IDLE;
          end
        end
        WR_ADDR: begin
          if (m_awready) state <= WR_DATA;
        end
        WR_DATA: begin
          if (wr_beat && last) state <= WR_RESP;
        end
        WR_RESP: begin
          if (m_bvalid) begin
            axi_done <= 1'b1;
            if (m_bresp != RESP_OKAY) err <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_burst_engine.sv
// Directed bench for axi_burst_engine with a bus-slave model and data scoreboards.
module tb_axi_burst_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_req, wr_req;
  logic [31:0] addr;
  logic        axi_done, err;
  logic [31:0] rd_data;
  logic        rd_fifo_full;
  logic [31:0] wr_fifo_data;
  logic        wr_fifo_empty;
  logic        wr_fifo_rd;
  logic [31:0] m_araddr, m_awaddr, m_rdata, m_wdata;
  logic [7:0]  m_arlen, m_awlen;
  logic [2:0]  m_arsize, m_awsize;
  logic [1:0]  m_arburst, m_awburst, m_rresp, m_bresp;
  logic        m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
  logic        m_awvalid, m_awready, m_wlast, m_wvalid, m_wready;
  logic [3:0]  m_wstrb;
  logic        m_bvalid, m_bready;
`ifdef WSTRB_PORT_EN
  logic [3:0]  wr_fifo_strb = 4'h6;
  localparam logic [3:0] EXP_STRB = 4'h6;
`else
  localparam logic [3:0] EXP_STRB = 4'hF;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] rq[$];
  logic [31:0] wq[$];
  logic [31:0] fifo[$];

  always #5 clk = ~clk;

  axi_burst_engine dut (
    .clk(clk), .reset(reset), .rd_req(rd_req), .wr_req(wr_req), .addr(addr),
    .axi_done(axi_done), .err(err), .rd_data(rd_data), .rd_fifo_full(rd_fifo_full),
    .wr_fifo_data(wr_fifo_data), .wr_fifo_empty(wr_fifo_empty),
`ifdef WSTRB_PORT_EN
    .wr_fifo_strb(wr_fifo_strb),
`endif
    .wr_fifo_rd(wr_fifo_rd),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_arvalid"}, 32'(m_arvalid), 0);
    chk({tag, "_rready"},  32'(m_rready), 0);
    chk({tag, "_awvalid"}, 32'(m_awvalid), 0);
    chk({tag, "_wvalid"},  32'(m_wvalid), 0);
    chk({tag, "_bready"},  32'(m_bready), 0);
    chk({tag, "_done"},    32'(axi_done), 0);
    chk({tag, "_fiford"},  32'(wr_fifo_rd), 0);
    chk({tag, "_err"},     32'(err), 0);
    chk({tag, "_rddata"},  rd_data, 0);
    chk({tag, "_araddr"},  m_araddr, 0);
  endtask

  // Read burst; full_at stalls that beat for 10 cycles, abort_at resets mid-burst.
  task automatic run_read(input logic [31:0] a, input int full_at, input int abort_at,
                          input bit hold_wr, input logic [31:0] wa);
    int i = 0, cyc = 0, dones = 0, lowc = 0, hold = 0, awv = 0;
    logic acc;
    logic [31:0] exp;
    @(negedge clk);
    rd_req = 1'b1; addr = a;
    if (hold_wr) wr_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    if (hold_wr) addr = wa;
    chk("arvalid", 32'(m_arvalid), 1);
    chk("awvalid_in_rd", 32'(m_awvalid), 0);
    chk("araddr", m_araddr, a);
    chk("arlen", 32'(m_arlen), 255);
    chk("arsize", 32'(m_arsize), 2);
    chk("arburst", 32'(m_arburst), 1);
    repeat (3) @(negedge clk);
    chk("arvalid_hold", 32'(m_arvalid), 1);
    m_arready = 1'b1;
    @(negedge clk);
    m_arready = 1'b0;
    chk("arvalid_drop", 32'(m_arvalid), 0);
    for (int k = 0; k < 256; k++) rq.push_back(32'(k) + 32'hDA7A_0000);
    while (i < 256 && cyc < 2000) begin
      if (i == abort_at) break;
      rd_fifo_full = (i == full_at) && (hold < 10);
      if (rd_fifo_full) hold++;
      m_rvalid = 1'b1; m_rdata = 32'(i) + 32'hDA7A_0000; m_rlast = (i == 255);
      #1;
      acc = m_rready;
      if (!acc) lowc++;
      if (m_awvalid) awv++;
      @(negedge clk);
      cyc++;
      if (acc) i++;
      if (axi_done) begin
        dones++;
        if (rq.size() > 0) exp = rq.pop_front(); else exp = 32'hBAD0_BAD0;
        chk("rd_data", rd_data, exp);
      end
    end
    m_rvalid = 1'b0; m_rlast = 1'b0; rd_fifo_full = 1'b0;
    if (abort_at < 256) begin
      reset = 1'b1;
      @(negedge clk);
      chk_quiet("abort");
      reset = 1'b0;
      rq.delete();
    end else begin
      chk("rd_beats", 32'(i), 256);
      chk("rd_dones", 32'(dones), 256);
      chk("rready_low", 32'(lowc), (full_at >= 0) ? 32'd10 : 32'd0);
      chk("aw_during_rd", 32'(awv), 0);
      chk("rready_idle", 32'(m_rready), 0);
      @(negedge clk);
      chk("rd_done_end", 32'(axi_done), 0);
    end
  endtask

  // Write burst with m_wready toggling; started=1 means WR_ADDR was already entered.
  task automatic run_write(input logic [31:0] a, input logic [1:0] bresp, input bit started,
                           input bit exp_err);
    int beat = 0, cyc = 0, pops = 0, lasts = 0, dones = 0;
    logic hs, pop, nonempty;
    logic [31:0] exp;
    if (!started) begin
      @(negedge clk);
      wr_req = 1'b1; addr = a;
      @(negedge clk);
    end
    wr_req = 1'b0;
    chk("awvalid", 32'(m_awvalid), 1);
    chk("arvalid_in_wr", 32'(m_arvalid), 0);
    chk("awaddr", m_awaddr, a);
    chk("awlen", 32'(m_awlen), 255);
    chk("awsize", 32'(m_awsize), 2);
    chk("awburst", 32'(m_awburst), 1);
    for (int k = 0; k < 256; k++) begin
      fifo.push_back(32'hC0DE_0000 | (32'(k) << 4) | 32'(a[31:28]));
      wq.push_back(32'hC0DE_0000 | (32'(k) << 4) | 32'(a[31:28]));
    end
    @(negedge clk);
    chk("awvalid_hold", 32'(m_awvalid), 1);
    m_awready = 1'b1;
    @(negedge clk);
    m_awready = 1'b0;
    chk("awvalid_drop", 32'(m_awvalid), 0);
    while (beat < 256 && cyc < 3000) begin
      m_wready = (cyc % 2 == 0);
      nonempty = (fifo.size() > 0);
      wr_fifo_empty = !nonempty;
      wr_fifo_data = nonempty ? fifo[0] : 32'h0;
      #1;
      chk("wvalid", 32'(m_wvalid), 32'(nonempty));
      hs = nonempty && m_wready;
      chk("wr_fifo_rd", 32'(wr_fifo_rd), 32'(hs));
      if (hs) begin
        if (wq.size() > 0) exp = wq.pop_front(); else exp = 32'hBAD0_BAD0;
        chk("wdata", m_wdata, exp);
        chk("wstrb", 32'(m_wstrb), 32'(EXP_STRB));
        chk("wlast", 32'(m_wlast), 32'(beat == 255));
        if (m_wlast) lasts++;
      end
      pop = wr_fifo_rd;
      @(negedge clk);
      cyc++;
      if (pop) begin void'(fifo.pop_front()); pops++; end
      if (hs) beat++;
      if (axi_done) dones++;
    end
    m_wready = 1'b0;
    wr_fifo_empty = (fifo.size() == 0);
    chk("wr_beats", 32'(beat), 256);
    chk("wr_pops", 32'(pops), 256);
    chk("wr_lasts", 32'(lasts), 1);
    chk("wr_early_done", 32'(dones), 0);
    #1;
    chk("bready", 32'(m_bready), 1);
    chk("done_pre_b", 32'(axi_done), 0);
    @(negedge clk);
    chk("bready_wait", 32'(m_bready), 1);
    chk("done_wait", 32'(axi_done), 0);
    m_bvalid = 1'b1; m_bresp = bresp;
    @(negedge clk);
    m_bvalid = 1'b0; m_bresp = 2'b00;
    chk("wr_done", 32'(axi_done), 1);
    chk("wr_err", 32'(err), 32'(exp_err));
    chk("bready_idle", 32'(m_bready), 0);
    @(negedge clk);
    chk("wr_done_end", 32'(axi_done), 0);
    wq.delete();
  endtask

  initial begin
    reset = 1'b1; rd_req = 1'b0; wr_req = 1'b0; addr = '0;
    rd_fifo_full = 1'b0; wr_fifo_data = '0; wr_fifo_empty = 1'b1;
    m_arready = 1'b0; m_rdata = '0; m_rresp = 2'b00; m_rlast = 1'b0; m_rvalid = 1'b0;
    m_awready = 1'b0; m_wready = 1'b0; m_bresp = 2'b00; m_bvalid = 1'b0;
    repeat (3) @(negedge clk);
    chk_quiet("reset");
    reset = 1'b0;

    run_read(32'h1000_0400, -1, 256, 1'b0, 32'h0);
    run_read(32'h2000_0800, 10, 256, 1'b0, 32'h0);
    run_write(32'h3000_0C00, 2'b00, 1'b0, 1'b0);
    // Simultaneous requests: read first, held write follows immediately.
    run_read(32'h4000_0000, -1, 256, 1'b1, 32'h5000_0400);
    run_write(32'h5000_0400, 2'b00, 1'b1, 1'b0);
    run_write(32'h6000_0000, 2'b10, 1'b0, 1'b1);
    run_read(32'h7000_0400, -1, 256, 1'b0, 32'h0);
    chk("err_sticky", 32'(err), 1);
    run_read(32'h1000_0400, -1, 100, 1'b0, 32'h0);
    run_read(32'h1000_0800, -1, 256, 1'b0, 32'h0);
    chk("err_after_reset", 32'(err), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_burst_engine.md
Name: axi_burst_engine

Overview:
- Bus-side responder to the hline_zbuff sequencer's request interface (rd_req/wr_req/addr/axi_done).
- Converts each request into one AXI4 INCR burst of BURST_LEN beats.
- Reads: streams returned beats into the pcore input FIFOs. Writes: drains the pcore output FIFO onto the bus.
- Sits between the sequencer/FIFOs and the AXI4 master port of the pcore.

Parameters:
- BURST_LEN, 256, beats per burst (1..256); ARLEN/AWLEN = BURST_LEN-1.
- DATA_W, 32, bus data width in bits (fixed at 32).
- ADDR_W, 32, byte address width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- rd_req  in  1  start read burst (sampled in IDLE only)
- wr_req  in  1  start write burst (sampled in IDLE only)
- addr  in  ADDR_W  burst start byte address, 1KB-aligned (caller guarantees)
- axi_done  out  1  read: one pulse per beat delivered; write: one pulse at burst completion
- err  out  1  sticky: any RRESP/BRESP != OKAY; cleared by reset
- rd_data  out  DATA_W  read beat to input FIFOs, valid while axi_done in a read
- rd_fifo_full  in  1  back-pressure from the input FIFO
- wr_fifo_data  in  DATA_W  output FIFO head (first-word-fall-through)
- wr_fifo_empty  in  1  output FIFO empty
- wr_fifo_rd  out  1  pop output FIFO
- m_araddr/m_arlen/m_arsize/m_arburst/m_arvalid out, m_arready in: AR channel (8-bit len, size=3'b010, burst=INCR)
- m_rdata/m_rresp/m_rlast/m_rvalid in, m_rready out: R channel
- m_awaddr/m_awlen/m_awsize/m_awburst/m_awvalid out, m_awready in: AW channel
- m_wdata/m_wstrb/m_wlast/m_wvalid out, m_wready in: W channel
- m_bresp/m_bvalid in, m_bready out: B channel

Behaviour:
- Reset: state IDLE, beat count 0. All valid, ready, axi_done, wr_fifo_rd and err outputs are 0; the address registers and rd_data are 0.
- A reset mid-burst aborts immediately to IDLE. Reset is system-wide, so the AXI slave is reset as well.
- States: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP.
- IDLE: if rd_req, latch addr and go to RD_ADDR. Else if wr_req, latch addr and go to WR_ADDR. Reads win when both are high.
- RD_ADDR: hold m_arvalid=1 with the latched address until m_arready, then go to RD_DATA with count=0.
- RD_DATA: m_rready = !rd_fifo_full. On each beat (m_rvalid & m_rready), register rd_data and pulse axi_done in the next cycle (1-cycle latency), then increment count.
  - On the beat where m_rlast is high, or count == BURST_LEN-1, go to IDLE. The final axi_done pulse occurs in IDLE.
- WR_ADDR: hold m_awvalid with the address until m_awready, then go to WR_DATA with count=0.
- WR_DATA: m_wdata = wr_fifo_data, m_wvalid = !wr_fifo_empty, wr_fifo_rd = m_wvalid & m_wready (combinational).
  - m_wlast = (count == BURST_LEN-1). On the last beat, go to WR_RESP.
- WR_RESP: m_bready=1. On m_bvalid, pulse axi_done for 1 cycle (registered) and go to IDLE.
- Responses: any response != 2'b00 sets err. The burst still completes with its full beat/done count.
- After any burst the engine spends at least one cycle in IDLE. A request held high there starts a new burst with the current addr.
- Beat count is 9 bits, so 256 is representable.

Optional Feature:
- Macro WSTRB_PORT_EN.
- Defined: adds input wr_fifo_strb[3:0], taken from the byte-enable FIFO in step with wr_fifo_data; m_wstrb = wr_fifo_strb.
- Undefined: no such port; m_wstrb = 4'hF.

Decomposition:
- Package axi_burst_pkg holds:
  - the state enum;
  - AXI constants: BURST_INCR=2'b01, SIZE_4B=3'b010, RESP_OKAY=2'b00;
  - BEAT_CNT_W=9.
- One sub-module, axi_beat_counter, shared by the R and W paths: clear, increment on beat, last-beat compare against BURST_LEN-1.

Test Plan:
- rd_req=1, addr=0x1000_0400, slave returns data 0..255 with m_arready after 3 cycles -> m_araddr=0x1000_0400, m_arlen=255; 256 axi_done pulses with rd_data 0..255 in order; IDLE after the last beat.
- Read with rd_fifo_full asserted for beats 10-19 -> m_rready low for exactly those cycles; no beat lost or duplicated.
- wr_req, FIFO holding 256 words, m_wready toggling 1/0 -> exactly 256 pops; m_wlast only on beat 255; single axi_done one cycle after m_bvalid.
- rd_req and wr_req both asserted in IDLE -> read burst issued first; write starts only after the read completes.
- BRESP=2'b10 on a write -> err=1 and stays high; axi_done still pulses; err clears only on reset.
- reset asserted at read beat 100 -> next cycle all valid/ready/axi_done=0, state IDLE; a new rd_req then runs a full 256-beat burst.
